// File: rtl/coax_tx_loader_pkg.sv
// Shared types and constants for the coax transmit loader.
package coax_tx_loader_pkg;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned WORD_W     = 10;
  localparam int unsigned WL_W       = 16;
  localparam int unsigned REPEAT_BIT = 7;

  typedef enum logic [2:0] {
    ST_LOW    = 3'd0,
    ST_HIGH   = 3'd1,
    ST_CNT_HI = 3'd2,
    ST_CNT_LO = 3'd3,
    ST_LOAD   = 3'd4,
    ST_START  = 3'd5
  } state_t;

  // States in which the loader takes a host byte.
  function automatic logic accepts_byte(input state_t s);
    return (s == ST_LOW) || (s == ST_HIGH) || (s == ST_CNT_HI) || (s == ST_CNT_LO);
  endfunction

endpackage

// File: rtl/coax_tx_loader_if.sv
// Host byte stream plus transmit-buffer write bus seen by the loader.
interface coax_tx_loader_if;
  import coax_tx_loader_pkg::*;

  logic [BYTE_W-1:0] byte_data;
  logic              byte_valid;
  logic              byte_last;
  logic              byte_ready;
  logic [WORD_W-1:0] tx_data;
  logic              tx_load_strobe;
  logic              tx_start_strobe;
  logic              tx_full;

  // Loader side: consumes host bytes, drives the transmit buffer.
  modport master (
    input  byte_data, byte_valid, byte_last, tx_full,
    output byte_ready, tx_data, tx_load_strobe, tx_start_strobe
  );

  // Environment side: host feeding bytes and buffer reporting full.
  modport slave (
    output byte_data, byte_valid, byte_last, tx_full,
    input  byte_ready, tx_data, tx_load_strobe, tx_start_strobe
  );

endinterface

// File: rtl/coax_tx_loader.sv
// Assembles 10-bit coax words from host bytes (with run-length repeat),
// writes them into the transmit buffer and requests start per message.
module coax_tx_loader
  import coax_tx_loader_pkg::*;
#(
  parameter bit          ENABLE_REPEAT = 1'b1,
  parameter int unsigned COUNT_WIDTH   = 16
) (
  input  logic             clk,
  input  logic             reset,
  coax_tx_loader_if.master bus,
  output logic             busy,
  output logic             error,
  output logic [WL_W-1:0]  words_loaded
);

  state_t                 state;
  state_t                 state_nxt;
  logic [COUNT_WIDTH-1:0] count;
  logic [COUNT_WIDTH-1:0] count_rx;
  logic                   last_flag;
  logic                   first_word;
  logic                   take;
  logic                   can_load;
  logic                   repeat_req;
  logic                   count_done;
  logic                   load_fire;
  logic                   start_fire;
  logic                   error_fire;

  assign take       = bus.byte_valid && bus.byte_ready;
  // Back-off one cycle after each load so a full flag raised by that load is seen.
  assign can_load   = !bus.tx_full && !bus.tx_load_strobe;
  assign repeat_req = ENABLE_REPEAT && bus.byte_data[REPEAT_BIT];
  assign count_rx   = {count[COUNT_WIDTH-1:BYTE_W], bus.byte_data};
  assign count_done = (count == COUNT_WIDTH'(1));

  // Next-state and one-cycle event decode.
  always_comb begin
    state_nxt  = state;
    load_fire  = 1'b0;
    start_fire = 1'b0;
    error_fire = 1'b0;
    unique case (state)
      ST_LOW: begin
        if (take) begin
          if (bus.byte_last) error_fire = 1'b1;
          else               state_nxt  = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (take) begin
          if (repeat_req) begin
            if (bus.byte_last) begin
              error_fire = 1'b1;
              state_nxt  = ST_LOW;
            end else begin
              state_nxt  = ST_CNT_HI;
            end
          end else if (can_load) begin
            load_fire = 1'b1;
            state_nxt = bus.byte_last ? ST_START : ST_LOW;
          end else begin
            state_nxt = ST_LOAD;
          end
        end
      end
      ST_CNT_HI: begin
        if (take) begin
          if (bus.byte_last) begin
            error_fire = 1'b1;
            state_nxt  = ST_LOW;
          end else begin
            state_nxt  = ST_CNT_LO;
          end
        end
      end
      ST_CNT_LO: begin
        if (take) begin
          if (count_rx == '0) state_nxt = bus.byte_last ? ST_START : ST_LOW;
          else                state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (can_load) begin
          load_fire = 1'b1;
          if (count_done) state_nxt = last_flag ? ST_START : ST_LOW;
        end
      end
      ST_START: begin
        // Hold off while the final load is still on the bus so the buffer flags settle.
        if (!bus.tx_load_strobe) begin
          start_fire = 1'b1;
          state_nxt  = ST_LOW;
        end
      end
      default: state_nxt = ST_LOW;
    endcase
  end

  // State register and registered control outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= ST_LOW;
      bus.byte_ready      <= 1'b0;
      bus.tx_load_strobe  <= 1'b0;
      bus.tx_start_strobe <= 1'b0;
      busy                <= 1'b0;
      error               <= 1'b0;
    end else begin
      state               <= state_nxt;
      bus.byte_ready      <= accepts_byte(state_nxt);
      bus.tx_load_strobe  <= load_fire;
      bus.tx_start_strobe <= start_fire;
      busy                <= (state_nxt != ST_LOW);
      error               <= error_fire;
    end
  end

  // Word, repeat count, message flags and load counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.tx_data  <= '0;
      count        <= '0;
      last_flag    <= 1'b0;
      first_word   <= 1'b1;
      words_loaded <= '0;
    end else begin
      if (take) begin
        unique case (state)
          ST_LOW:    bus.tx_data[BYTE_W-1:0] <= bus.byte_data;
          ST_HIGH: begin
            bus.tx_data[WORD_W-1:BYTE_W] <= bus.byte_data[WORD_W-BYTE_W-1:0];
            last_flag                    <= bus.byte_last;
            count                        <= COUNT_WIDTH'(1);
          end
          ST_CNT_HI: count[COUNT_WIDTH-1:BYTE_W] <= bus.byte_data;
          ST_CNT_LO: begin
            count     <= count_rx;
            last_flag <= bus.byte_last;
          end
          default: ;
        endcase
      end

      if ((state == ST_LOAD) && load_fire) count <= count - COUNT_WIDTH'(1);

      if (take && (state == ST_LOW) && first_word && !bus.byte_last)
        words_loaded <= '0;
      else if (load_fire && (words_loaded != '1))
        words_loaded <= words_loaded + WL_W'(1);

      if (error_fire || start_fire)
        first_word <= 1'b1;
      else if (take && (state == ST_LOW))
        first_word <= 1'b0;
    end
  end

endmodule

// File: tb/tb_coax_tx_loader.sv
// Directed, table-driven bench for coax_tx_loader (repeat on and off).
module tb_coax_tx_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        busy, error, busy_nr, error_nr;
  logic [15:0] words_loaded, words_loaded_nr;
  int          cyc = 0;

  coax_tx_loader_if bus();
  coax_tx_loader_if bus_nr();

  coax_tx_loader #(.ENABLE_REPEAT(1'b1), .COUNT_WIDTH(16)) u_dut (
    .clk(clk), .reset(reset), .bus(bus),
    .busy(busy), .error(error), .words_loaded(words_loaded)
  );

  coax_tx_loader #(.ENABLE_REPEAT(1'b0), .COUNT_WIDTH(16)) u_norep (
    .clk(clk), .reset(reset), .bus(bus_nr),
    .busy(busy_nr), .error(error_nr), .words_loaded(words_loaded_nr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          n;
    logic [31:0] b;       // byte j at b[8*j +: 8]
    logic [3:0]  lastv;   // byte_last per byte
    int          loads;
    logic [9:0]  word;
    int          starts;
    int          errs;
    int          wl;
    bit          chk_word;
    bit          chk_wl;
    bit          chk_lat;
  } vec_t;

  vec_t vecs [8];
  int   passed = 0;
  int   total  = 0;

  // Output monitors sampled on the falling edge.
  int         n_loads = 0, n_starts = 0, n_errs = 0, gap_viol = 0, overlap = 0;
  int         load_cyc = 0, start_cyc = 0;
  logic [9:0] last_word = '0;
  int         n_loads_nr = 0, n_starts_nr = 0;
  logic [9:0] words_nr [4];
  int         acc_cyc = 0;

  always @(negedge clk) begin
    if (bus.tx_load_strobe) begin
      if (n_loads > 0 && (cyc - load_cyc) < 2) gap_viol++;
      n_loads++;
      load_cyc  = cyc;
      last_word = bus.tx_data;
    end
    if (bus.tx_start_strobe) begin
      n_starts++;
      start_cyc = cyc;
    end
    if (error) n_errs++;
    if (error && (bus.tx_load_strobe || bus.tx_start_strobe)) overlap++;
    if (bus_nr.tx_load_strobe) begin
      if (n_loads_nr < 4) words_nr[n_loads_nr] = bus_nr.tx_data;
      n_loads_nr++;
    end
    if (bus_nr.tx_start_strobe) n_starts_nr++;
  end

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
  endtask

  function automatic vec_t mk(input int n, input logic [31:0] b, input logic [3:0] lastv,
                              input int loads, input logic [9:0] word, input int starts,
                              input int errs, input int wl, input bit cw, input bit cwl,
                              input bit cl);
    vec_t v;
    v.n = n; v.b = b; v.lastv = lastv; v.loads = loads; v.word = word;
    v.starts = starts; v.errs = errs; v.wl = wl;
    v.chk_word = cw; v.chk_wl = cwl; v.chk_lat = cl;
    return v;
  endfunction

  // Present one byte and hold it until it is accepted (bounded).
  task automatic send_byte(input bit nr, input logic [7:0] d, input logic l);
    int   n;
    logic rdy;
    @(negedge clk);
    if (nr) begin
      bus_nr.byte_data = d; bus_nr.byte_last = l; bus_nr.byte_valid = 1'b1;
    end else begin
      bus.byte_data = d; bus.byte_last = l; bus.byte_valid = 1'b1;
    end
    n   = 0;
    rdy = nr ? bus_nr.byte_ready : bus.byte_ready;
    while (!rdy && n < 500) begin
      @(negedge clk);
      n++;
      rdy = nr ? bus_nr.byte_ready : bus.byte_ready;
    end
    acc_cyc = cyc;
    check("byte_accept", 64'(rdy), 1);
    if (rdy) @(posedge clk);
    #1;
    if (nr) bus_nr.byte_valid = 1'b0;
    else    bus.byte_valid = 1'b0;
  endtask

  // Wait until the loader has been quiet for three cycles (bounded).
  task automatic wait_idle(input bit nr);
    int   quiet = 0;
    int   n = 0;
    logic idle;
    while (quiet < 3 && n < 3000) begin
      @(negedge clk);
      n++;
      if (nr) idle = !busy_nr && bus_nr.byte_ready && !bus_nr.tx_load_strobe && !bus_nr.tx_start_strobe;
      else    idle = !busy && bus.byte_ready && !bus.tx_load_strobe && !bus.tx_start_strobe;
      quiet = idle ? quiet + 1 : 0;
    end
    check("idle_reached", 64'(quiet >= 3), 1);
    #1;
  endtask

  initial begin
    int l0, s0, e0, held_loads, rdy_seen, strobes;

    bus.byte_data = '0;    bus.byte_valid = 1'b0;    bus.byte_last = 1'b0;    bus.tx_full = 1'b0;
    bus_nr.byte_data = '0; bus_nr.byte_valid = 1'b0; bus_nr.byte_last = 1'b0; bus_nr.tx_full = 1'b0;

    vecs[0] = mk(2, 32'h0000_0255, 4'b0010, 1, 10'h255, 1, 0, 1, 1, 1, 1);
    vecs[1] = mk(4, 32'h0500_8100, 4'b1000, 5, 10'h100, 1, 0, 5, 1, 1, 0);
    vecs[2] = mk(1, 32'h0000_0012, 4'b0001, 0, 10'h000, 0, 1, 0, 0, 0, 0);
    vecs[3] = mk(2, 32'h0000_0134, 4'b0010, 1, 10'h134, 1, 0, 1, 1, 1, 1);
    vecs[4] = mk(4, 32'h0000_80AA, 4'b1000, 0, 10'h000, 1, 0, 0, 0, 1, 0);
    vecs[5] = mk(4, 32'h0302_0001, 4'b1000, 2, 10'h302, 1, 0, 2, 1, 1, 1);
    vecs[6] = mk(3, 32'h0000_8007, 4'b0100, 0, 10'h000, 0, 1, 0, 0, 0, 0);
    vecs[7] = mk(2, 32'h0000_8107, 4'b0010, 0, 10'h000, 0, 1, 0, 0, 0, 0);

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_byte_ready", 64'(bus.byte_ready), 0);
    check("rst_tx_data", 64'(bus.tx_data), 0);
    check("rst_load", 64'(bus.tx_load_strobe), 0);
    check("rst_start", 64'(bus.tx_start_strobe), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_error", 64'(error), 0);
    check("rst_words_loaded", 64'(words_loaded), 0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 64'(bus.byte_ready), 1);

    // Message table.
    for (int i = 0; i < 8; i++) begin
      l0 = n_loads; s0 = n_starts; e0 = n_errs;
      for (int j = 0; j < vecs[i].n; j++)
        send_byte(1'b0, vecs[i].b[8*j +: 8], vecs[i].lastv[j]);
      wait_idle(1'b0);
      check($sformatf("v%0d_loads", i), n_loads - l0, vecs[i].loads);
      check($sformatf("v%0d_starts", i), n_starts - s0, vecs[i].starts);
      check($sformatf("v%0d_errors", i), n_errs - e0, vecs[i].errs);
      if (vecs[i].chk_word) check($sformatf("v%0d_tx_data", i), 64'(last_word), 64'(vecs[i].word));
      if (vecs[i].chk_wl) check($sformatf("v%0d_words_loaded", i), 64'(words_loaded), vecs[i].wl);
      if (vecs[i].chk_lat) begin
        check($sformatf("v%0d_load_latency", i), load_cyc - acc_cyc, 1);
        check($sformatf("v%0d_start_latency", i), start_cyc - load_cyc, 2);
      end
    end
    check("start_after_final_load", start_cyc - load_cyc, 2);

    // Full held high in the middle of a repeat of 10.
    l0 = n_loads; s0 = n_starts;
    send_byte(1'b0, 8'h00, 1'b0);
    send_byte(1'b0, 8'h83, 1'b0);
    send_byte(1'b0, 8'h00, 1'b0);
    send_byte(1'b0, 8'h0A, 1'b1);
    repeat (4) @(negedge clk);
    bus.tx_full = 1'b1;
    held_loads = 0; rdy_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.tx_load_strobe) held_loads++;
      if (bus.byte_ready) rdy_seen++;
    end
    #1;
    check("full_no_loads", held_loads, 0);
    check("full_no_ready", rdy_seen, 0);
    check("full_mid_repeat", 64'((n_loads - l0) > 0 && (n_loads - l0) < 10), 1);
    bus.tx_full = 1'b0;
    wait_idle(1'b0);
    check("full_total_loads", n_loads - l0, 10);
    check("full_starts", n_starts - s0, 1);
    check("full_words_loaded", 64'(words_loaded), 10);
    check("full_tx_data", 64'(last_word), 64'(10'h300));

    // Repeat bit ignored when repeat encoding is disabled.
    send_byte(1'b1, 8'h34, 1'b0);
    send_byte(1'b1, 8'h80, 1'b0);
    send_byte(1'b1, 8'h00, 1'b0);
    send_byte(1'b1, 8'h01, 1'b1);
    wait_idle(1'b1);
    check("norep_loads", n_loads_nr, 2);
    check("norep_word0", 64'(words_nr[0]), 64'(10'h034));
    check("norep_word1", 64'(words_nr[1]), 64'(10'h100));
    check("norep_starts", n_starts_nr, 1);
    check("norep_words_loaded", 64'(words_loaded_nr), 2);

    // Reset in the middle of a repeat of 100.
    send_byte(1'b0, 8'h11, 1'b0);
    send_byte(1'b0, 8'h81, 1'b0);
    send_byte(1'b0, 8'h00, 1'b0);
    send_byte(1'b0, 8'h64, 1'b1);
    repeat (10) @(negedge clk);
    check("pre_rst_busy", 64'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_ready", 64'(bus.byte_ready), 0);
    check("mid_rst_tx_data", 64'(bus.tx_data), 0);
    check("mid_rst_load", 64'(bus.tx_load_strobe), 0);
    check("mid_rst_start", 64'(bus.tx_start_strobe), 0);
    check("mid_rst_busy", 64'(busy), 0);
    check("mid_rst_words_loaded", 64'(words_loaded), 0);
    @(negedge clk);
    check("mid_rst_ready_back", 64'(bus.byte_ready), 1);
    strobes = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.tx_load_strobe || bus.tx_start_strobe) strobes++;
    end
    check("mid_rst_no_strobes", strobes, 0);
    check("mid_rst_wl_still_0", 64'(words_loaded), 0);

    // Recovery after reset.
    l0 = n_loads; s0 = n_starts;
    send_byte(1'b0, 8'h55, 1'b0);
    send_byte(1'b0, 8'h02, 1'b1);
    wait_idle(1'b0);
    check("recover_loads", n_loads - l0, 1);
    check("recover_tx_data", 64'(last_word), 64'(10'h255));
    check("recover_starts", n_starts - s0, 1);
    check("recover_words_loaded", 64'(words_loaded), 1);

    check("load_spacing", gap_viol, 0);
    check("error_overlap", overlap, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
